// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and constants for the stopwatch core: the FSM
//                state encoding and the BCD digit limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // BCD digit limits: ones digits run 0..9, tens digits run 0..5
    localparam logic [3:0] c_BCD_NINE = 4'd9;
    localparam logic [3:0] c_BCD_FIVE = 4'd5;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_core_bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : Single 4-bit BCD counter digit with configurable wrap value.
//                Counts up on inc, wraps from MAX to 0 and flags carry in the
//                same cycle so digits can be chained into a cascade.
//  Ports       : clk_in - system clock
//                rst    - synchronous active-high reset
//                inc    - advance the digit by one
//                clr    - synchronous clear (wins over inc)
//                value  - registered digit value, 0..MAX
//                carry  - combinational: inc AND value == MAX
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = c_BCD_NINE
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] r_value;

    always_ff @(posedge clk_in) begin
        if (rst || clr) begin
            r_value <= 4'd0;
        end else if (inc) begin
            // >= rather than == keeps the digit legal even from a corrupted value
            if (r_value >= MAX) begin
                r_value <= 4'd0;
            end else begin
                r_value <= r_value + 4'd1;
            end
        end
    end

    assign value = r_value;
    assign carry = inc && (r_value == MAX);

endmodule : bcd_digit
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_core
//  Description : MM:SS stopwatch. Detects rising edges of the (synchronous)
//                slow_clk input, counts TICKS_PER_SEC of them per second while
//                running, and advances a four-digit BCD display cascade.
//  Ports       : clk_in     - system clock
//                rst        - synchronous active-high reset
//                slow_clk   - divided clock, sampled as data
//                start_stop - one-cycle pulse toggling run/pause
//                clear      - one-cycle pulse zeroing the time and stopping
//                min_tens, min_ones, sec_tens, sec_ones - BCD digits
//                running    - high while in RUN
//                rollover   - one-cycle pulse on the 59:59 -> 00:00 wrap
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       slow_clk,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       rollover
);

    localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [SUB_W-1:0] c_SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_slow_clk_q;
    logic [SUB_W-1:0] r_sub_cnt;
    logic             r_rollover;

    logic             w_tick;
    logic             w_count;
    logic             w_sec_pulse;
    logic             w_so_carry;
    logic             w_st_carry;
    logic             w_mo_carry;
    logic             w_mt_carry;

    // ------------------------------------------------------------------
    // slow_clk rising-edge detector
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_slow_clk_q <= 1'b0;
        end else begin
            r_slow_clk_q <= slow_clk;
        end
    end

    assign w_tick = slow_clk && !r_slow_clk_q;

    // Gating on the registered state means a start_stop in the same cycle
    // does not affect whether this tick is counted.
    assign w_count     = w_tick && (r_state == RUN);
    assign w_sec_pulse = w_count && (r_sub_cnt == c_SUB_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else if (start_stop) begin
            case (r_state)
                IDLE:    w_state_next = RUN;
                RUN:     w_state_next = PAUSE;
                PAUSE:   w_state_next = RUN;
                default: w_state_next = IDLE;
            endcase
        end else if (r_state != IDLE && r_state != RUN && r_state != PAUSE) begin
            w_state_next = IDLE;
        end
    end

    assign running = (r_state == RUN);

    // ------------------------------------------------------------------
    // Sub-second tick counter; held (not cleared) in PAUSE
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst || clear) begin
            r_sub_cnt <= '0;
        end else if (w_count) begin
            if (r_sub_cnt >= c_SUB_LAST) begin
                r_sub_cnt <= '0;
            end else begin
                r_sub_cnt <= r_sub_cnt + SUB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // BCD cascade: SS ones -> SS tens -> MM ones -> MM tens
    // ------------------------------------------------------------------
    bcd_digit #(.MAX(c_BCD_NINE)) u_sec_ones (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (w_sec_pulse),
        .clr    (clear),
        .value  (sec_ones),
        .carry  (w_so_carry)
    );

    bcd_digit #(.MAX(c_BCD_FIVE)) u_sec_tens (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (w_so_carry),
        .clr    (clear),
        .value  (sec_tens),
        .carry  (w_st_carry)
    );

    bcd_digit #(.MAX(c_BCD_NINE)) u_min_ones (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (w_st_carry),
        .clr    (clear),
        .value  (min_ones),
        .carry  (w_mo_carry)
    );

    bcd_digit #(.MAX(c_BCD_FIVE)) u_min_tens (
        .clk_in (clk_in),
        .rst    (rst),
        .inc    (w_mo_carry),
        .clr    (clear),
        .value  (min_tens),
        .carry  (w_mt_carry)
    );

    // Registered so the pulse lands on the same edge the digits show 00:00;
    // a coincident clear zeroes the time without signalling a wrap.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= w_mt_carry && !clear;
        end
    end

    assign rollover = r_rollover;

endmodule : stopwatch_core
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_core
//  Description : Directed self-checking bench for stopwatch_core with
//                TICKS_PER_SEC = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_core;

    logic       clk_in;
    logic       rst;
    logic       slow_clk;
    logic       start_stop;
    logic       clear;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       rollover;

    int checks;
    int errors;

    stopwatch_core #(.TICKS_PER_SEC(4)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .slow_clk   (slow_clk),
        .start_stop (start_stop),
        .clear      (clear),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .rollover   (rollover)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic logic [15:0] disp();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One slow_clk rising edge: high for one cycle, low for one cycle
    task automatic slow_edge();
        slow_clk = 1'b1;
        step();
        slow_clk = 1'b0;
        step();
    endtask

    task automatic slow_edges(input int n);
        for (int i = 0; i < n; i++) slow_edge();
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
    endtask

    initial begin
        logic saw_roll;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        slow_clk   = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;

        // ---- reset state, no counting while idle ----
        do_reset(3);
        check_val("reset_time", 32'(disp()), 32'h0000);
        check_val("reset_running", 32'(running), 32'd0);
        check_val("reset_rollover", 32'(rollover), 32'd0);
        slow_edges(10);
        check_val("idle_no_count", 32'(disp()), 32'h0000);

        // ---- basic counting ----
        pulse_start();
        check_val("run_running", 32'(running), 32'd1);
        slow_edges(3);
        check_val("three_ticks", 32'(disp()), 32'h0000);
        slow_clk = 1'b1;
        step();
        check_val("fourth_tick_latency", 32'(disp()), 32'h0001);
        slow_clk = 1'b0;
        step();
        slow_edges(36);
        check_val("forty_ticks", 32'(disp()), 32'h0010);

        // ---- pause preserves partial second ----
        do_reset(1);
        pulse_start();
        slow_edges(2);
        pulse_start();
        check_val("pause_running", 32'(running), 32'd0);
        slow_edges(5);
        check_val("pause_hold", 32'(disp()), 32'h0000);
        pulse_start();
        slow_edge();
        check_val("resume_third", 32'(disp()), 32'h0000);
        slow_edge();
        check_val("resume_fourth", 32'(disp()), 32'h0001);

        // ---- full-hour rollover ----
        do_reset(1);
        pulse_start();
        saw_roll = 1'b0;
        for (int i = 0; i < 14399; i++) begin
            slow_clk = 1'b1;
            step();
            if (rollover) saw_roll = 1'b1;
            slow_clk = 1'b0;
            step();
            if (rollover) saw_roll = 1'b1;
        end
        check_val("no_early_rollover", 32'(saw_roll), 32'd0);
        check_val("at_5959", 32'(disp()), 32'h5959);
        slow_clk = 1'b1;
        step();
        check_val("wrap_time", 32'(disp()), 32'h0000);
        check_val("wrap_rollover", 32'(rollover), 32'd1);
        check_val("wrap_running", 32'(running), 32'd1);
        slow_clk = 1'b0;
        step();
        check_val("rollover_one_cycle", 32'(rollover), 32'd0);
        slow_edges(4);
        check_val("after_wrap_count", 32'(disp()), 32'h0001);

        // ---- clear + start together while running at 00:07 ----
        do_reset(1);
        pulse_start();
        slow_edges(28);
        check_val("at_0007", 32'(disp()), 32'h0007);
        slow_edges(2);
        clear      = 1'b1;
        start_stop = 1'b1;
        step();
        clear      = 1'b0;
        start_stop = 1'b0;
        check_val("clear_time", 32'(disp()), 32'h0000);
        check_val("clear_running", 32'(running), 32'd0);
        pulse_start();
        slow_edges(3);
        check_val("clear_sub_zeroed", 32'(disp()), 32'h0000);
        slow_edge();
        check_val("clear_restart", 32'(disp()), 32'h0001);

        // ---- tick coincident with start out of IDLE is not counted ----
        do_reset(1);
        slow_clk   = 1'b1;
        start_stop = 1'b1;
        step();
        slow_clk   = 1'b0;
        start_stop = 1'b0;
        step();
        check_val("coinc_running", 32'(running), 32'd1);
        slow_edges(3);
        check_val("coinc_not_counted", 32'(disp()), 32'h0000);
        slow_edge();
        check_val("coinc_fourth", 32'(disp()), 32'h0001);

        // ---- tick coincident with start out of RUN is counted ----
        slow_edges(3);
        slow_clk   = 1'b1;
        start_stop = 1'b1;
        step();
        slow_clk   = 1'b0;
        start_stop = 1'b0;
        check_val("run_exit_tick_counted", 32'(disp()), 32'h0002);
        check_val("run_exit_paused", 32'(running), 32'd0);

        // ---- tick coincident with rst, and on the release cycle ----
        pulse_start();
        rst      = 1'b1;
        slow_clk = 1'b1;
        step();
        rst      = 1'b0;
        check_val("rst_tick_time", 32'(disp()), 32'h0000);
        check_val("rst_tick_running", 32'(running), 32'd0);
        step();
        slow_clk = 1'b0;
        step();
        pulse_start();
        slow_edges(4);
        check_val("post_rst_count", 32'(disp()), 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_stopwatch_core
`default_nettype wire
